// File: rtl/rex_game_core.sv
// Rex runner game core: state machine, jump model, obstacle slots, score.
// Define REX_SPEEDUP_EN to raise obstacle speed as points accumulate.
module rex_game_core #(
  parameter int N_OBS       = 2,
  parameter int REX_X       = 16,
  parameter int REX_W       = 16,
  parameter int OBS_W       = 16,
  parameter int OBS_H       = 26,
  parameter int JUMP_V      = 16,
  parameter int GRAVITY     = 2,
  parameter int SPAWN_X     = 240,
  parameter int OBS_GAP     = 120,
  parameter int SPEED0      = 8,
  parameter int SPEED_MAX   = 16,
  parameter int SPEEDUP_PTS = 10
) (
  input  logic                 clk120kHz,
  input  logic                 rst,
  input  logic                 clk6Hz,
  input  logic                 in_up,
  output logic [15:0]          rex_y,
  output logic [16*N_OBS-1:0]  obs_left,
  output logic [N_OBS-1:0]     obs_valid,
  output logic [15:0]          score,
  output logic [1:0]           game_state
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd3
  } state_t;

  localparam logic [15:0] L_SPAWN  = 16'(SPAWN_X);
  localparam logic [15:0] L_THR    = 16'(SPAWN_X - OBS_GAP);
  localparam logic [15:0] L_HIT_R  = 16'(REX_X + REX_W);
  localparam logic [16:0] L_HIT_L  = 17'(REX_X);
  localparam logic [16:0] L_OBS_W  = 17'(OBS_W);
  localparam logic [15:0] L_OBS_H  = 16'(OBS_H);
  localparam logic [7:0]  L_JV     = 8'(JUMP_V);
  localparam logic [7:0]  L_GRAV   = 8'(GRAVITY);
  localparam logic [15:0] L_SPEED0 =
    16'((SPEED0 > SPEED_MAX) ? SPEED_MAX : SPEED0);

  if (N_OBS < 1 || N_OBS > 4 || SPEEDUP_PTS < 1) begin : g_bad_cfg
    $error("rex_game_core: unsupported parameters");
  end

  state_t           r_state;
  logic             r_clk6_d;
  logic             r_up_d;
  logic             r_jreq;
  logic [15:0]      r_rex_y;
  logic [7:0]       r_vy;
  logic [15:0]      r_score;
  logic [15:0]      r_obs [N_OBS];
  logic [N_OBS-1:0] r_valid;

  logic             w_tick;
  logic             w_key;
  logic             w_hit;
  logic             w_step;
  logic             w_clear;
  logic [15:0]      w_speed;
  logic [16:0]      w_h_next;
  logic [15:0]      w_rex_n;
  logic [7:0]       w_vy_n;
  logic [15:0]      w_obs_n [N_OBS];
  logic [N_OBS-1:0] w_val_n;
  logic [2:0]       w_nscored;
  logic [16:0]      w_score_sum;
  logic [15:0]      w_score_n;
  logic             w_block;
  logic             w_done;

  assign w_tick  = clk6Hz & ~r_clk6_d;
  assign w_key   = in_up & ~r_up_d;
  assign w_step  = (r_state == ST_PLAY) && w_tick && !w_hit;
  assign w_clear = (r_state == ST_OVER) && w_key;

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < N_OBS; i++) begin
      if (r_valid[i] && (r_obs[i] < L_HIT_R) &&
          (({1'b0, r_obs[i]} + L_OBS_W) > L_HIT_L) &&
          (r_rex_y < L_OBS_H))
        w_hit = 1'b1;
    end
  end

  // vy is two's complement; bit 16 of the sum flags a landing below ground
  assign w_h_next = {1'b0, r_rex_y} + {{9{r_vy[7]}}, r_vy};

  always_comb begin
    w_rex_n = r_rex_y;
    w_vy_n  = r_vy;
    if (r_rex_y == '0 && r_vy == '0) begin
      if (r_jreq || w_key) w_vy_n = L_JV;
    end else if (w_h_next[16] || w_h_next == '0) begin
      w_rex_n = '0;
      w_vy_n  = '0;
    end else begin
      w_rex_n = w_h_next[15:0];
      w_vy_n  = r_vy - L_GRAV;
    end
  end

  always_comb begin
    w_obs_n   = r_obs;
    w_val_n   = r_valid;
    w_nscored = '0;
    w_block   = 1'b0;
    w_done    = 1'b0;
    for (int i = 0; i < N_OBS; i++) begin
      if (r_valid[i]) begin
        if (r_obs[i] < w_speed) begin
          w_val_n[i] = 1'b0;
          w_nscored  = w_nscored + 3'd1;
        end else begin
          w_obs_n[i] = r_obs[i] - w_speed;
        end
      end
    end
    for (int i = 0; i < N_OBS; i++)
      if (w_val_n[i] && w_obs_n[i] > L_THR) w_block = 1'b1;
    for (int i = 0; i < N_OBS; i++) begin
      if (!w_block && !w_done && !w_val_n[i]) begin
        w_val_n[i] = 1'b1;
        w_obs_n[i] = L_SPAWN;
        w_done     = 1'b1;
      end
    end
  end

  assign w_score_sum = {1'b0, r_score} + 17'(w_nscored);
  assign w_score_n   = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];

  always_ff @(posedge clk120kHz) begin
    if (rst) begin
      r_state  <= ST_INIT;
      r_clk6_d <= 1'b0;
      r_up_d   <= 1'b0;
      r_jreq   <= 1'b0;
      r_rex_y  <= '0;
      r_vy     <= '0;
      r_score  <= '0;
      r_valid  <= '0;
      for (int i = 0; i < N_OBS; i++) r_obs[i] <= '0;
    end else begin
      r_clk6_d <= clk6Hz;
      r_up_d   <= in_up;
      unique case (r_state)
        ST_INIT: begin
          if (w_key) r_state <= ST_PLAY;
        end
        ST_PLAY: begin
          if (w_hit) begin
            r_state <= ST_OVER;
          end else if (w_step) begin
            r_jreq  <= 1'b0;
            r_rex_y <= w_rex_n;
            r_vy    <= w_vy_n;
            r_obs   <= w_obs_n;
            r_valid <= w_val_n;
            r_score <= w_score_n;
          end else if (w_key) begin
            r_jreq <= 1'b1;
          end
        end
        ST_OVER: begin
          if (w_clear) begin
            r_state <= ST_INIT;
            r_jreq  <= 1'b0;
            r_rex_y <= '0;
            r_vy    <= '0;
            r_score <= '0;
            r_valid <= '0;
            for (int i = 0; i < N_OBS; i++) r_obs[i] <= '0;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

`ifdef REX_SPEEDUP_EN
  logic [15:0] r_speed;
  logic [15:0] r_pts;
  logic [15:0] w_pts_sum;

  assign w_speed   = r_speed;
  assign w_pts_sum = r_pts + 16'(w_nscored);

  always_ff @(posedge clk120kHz) begin
    if (rst || w_clear) begin
      r_speed <= L_SPEED0;
      r_pts   <= '0;
    end else if (w_step && w_nscored != '0) begin
      if (w_pts_sum >= 16'(SPEEDUP_PTS)) begin
        r_pts <= '0;
        if (r_speed < 16'(SPEED_MAX)) r_speed <= r_speed + 16'd1;
      end else begin
        r_pts <= w_pts_sum;
      end
    end
  end
`else
  assign w_speed = L_SPEED0;
`endif

  for (genvar g = 0; g < N_OBS; g++) begin : g_out
    assign obs_left[16*g +: 16] = r_obs[g];
  end

  assign obs_valid  = r_valid;
  assign rex_y      = r_rex_y;
  assign score      = r_score;
  assign game_state = r_state;

endmodule

// File: tb/tb_rex_game_core.sv
// Directed bench for rex_game_core: reset, spawn, jump, scoring, collision.
// Uses SPEEDUP_PTS=2 so a speed step is reachable with avoidable obstacles.
module tb_rex_game_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk6 = 1'b0;
  logic        up = 1'b0;
  logic [15:0] rex_y;
  logic [31:0] obs_left;
  logic [1:0]  obs_valid;
  logic [15:0] score;
  logic [1:0]  gs;

  int n_vec = 0;
  int n_err = 0;

  int prof [17] = '{16, 30, 42, 52, 60, 66, 70, 72, 72,
                    70, 66, 60, 52, 42, 30, 16, 0};

`ifdef REX_SPEEDUP_EN
  localparam logic [15:0] E48_0 = 16'd111;
  localparam logic [15:0] E48_1 = 16'd231;
`else
  localparam logic [15:0] E48_0 = 16'd112;
  localparam logic [15:0] E48_1 = 16'd232;
`endif

  always #5 clk = ~clk;

  rex_game_core #(.SPEEDUP_PTS(2)) dut (
    .clk120kHz (clk),
    .rst       (rst),
    .clk6Hz    (clk6),
    .in_up     (up),
    .rex_y     (rex_y),
    .obs_left  (obs_left),
    .obs_valid (obs_valid),
    .score     (score),
    .game_state(gs)
  );

  task automatic tick();
    @(negedge clk); clk6 = 1'b1;
    @(negedge clk); clk6 = 1'b0;
  endtask

  task automatic key();
    @(negedge clk); up = 1'b1;
    @(negedge clk); up = 1'b0;
  endtask

  task automatic key_tick();
    @(negedge clk); up = 1'b1; clk6 = 1'b1;
    @(negedge clk); up = 1'b0; clk6 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      up   = 1'($urandom_range(0, 1));
      clk6 = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    n_vec++;
    if ({rex_y, obs_left, obs_valid, score, gs} !== '0) begin
      n_err++;
      $display("FAIL reset: rex_y=%0d obs=%h v=%b score=%0d st=%0d, want all 0",
               rex_y, obs_left, obs_valid, score, gs);
    end
    rst = 1'b0; up = 1'b0; clk6 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_init_idle();
    tick();
    n_vec++;
    if (obs_valid !== 2'b00 || gs !== 2'd0) begin
      n_err++;
      $display("FAIL init_idle: v=%b st=%0d, want v=00 st=0", obs_valid, gs);
    end
  endtask

  task automatic test_spawn();
    key();
    n_vec++;
    if (gs !== 2'd1) begin
      n_err++;
      $display("FAIL start: st=%0d, want 1", gs);
    end
    for (int k = 1; k <= 19; k++) begin
      tick();
      n_vec++;
      if (obs_left[15:0] !== 16'(240 - 8 * (k - 1)) || obs_valid[0] !== 1'b1) begin
        n_err++;
        $display("FAIL slot0 tick %0d: got %0d v=%b, want %0d valid",
                 k, obs_left[15:0], obs_valid, 240 - 8 * (k - 1));
      end
      if (k == 1) begin
        n_vec++;
        if (rex_y !== 16'd0) begin
          n_err++;
          $display("FAIL first_tick_rex: got %0d, want 0", rex_y);
        end
      end
      if (k == 15) begin
        n_vec++;
        if (obs_valid !== 2'b01) begin
          n_err++;
          $display("FAIL no_early_spawn: v=%b, want 01", obs_valid);
        end
      end
      if (k == 16) begin
        n_vec++;
        if (obs_valid !== 2'b11 || obs_left[31:16] !== 16'd240) begin
          n_err++;
          $display("FAIL slot1_spawn: v=%b slot1=%0d, want 11 240",
                   obs_valid, obs_left[31:16]);
        end
      end
    end
  endtask

  task automatic test_jump();
    int exp;
    key();
    for (int k = 20; k <= 37; k++) begin
      tick();
      exp = (k == 20) ? 0 : prof[k - 21];
      n_vec++;
      if (rex_y !== 16'(exp)) begin
        n_err++;
        $display("FAIL jump tick %0d: rex_y=%0d, want %0d", k, rex_y, exp);
      end
      if (k >= 28 && k <= 31) begin
        n_vec++;
        if (gs !== 2'd1 || obs_left[15:0] !== 16'(240 - 8 * (k - 1))) begin
          n_err++;
          $display("FAIL clear_jump tick %0d: st=%0d slot0=%0d, want 1 %0d",
                   k, gs, obs_left[15:0], 240 - 8 * (k - 1));
        end
      end
      if (k == 32) begin
        n_vec++;
        if (score !== 16'd1 || obs_left[15:0] !== 16'd240 || obs_valid !== 2'b11) begin
          n_err++;
          $display("FAIL retire0: score=%0d slot0=%0d v=%b, want 1 240 11",
                   score, obs_left[15:0], obs_valid);
        end
      end
      if (k == 22) key();
    end
  endtask

  task automatic test_score();
    tick();
    n_vec++;
    if (rex_y !== 16'd0) begin
      n_err++;
      $display("FAIL landed_38: rex_y=%0d, want 0", rex_y);
    end
    key_tick();
    n_vec++;
    if (rex_y !== 16'd0) begin
      n_err++;
      $display("FAIL key_tick_39: rex_y=%0d, want 0", rex_y);
    end
    for (int k = 40; k <= 48; k++) begin
      tick();
      n_vec++;
      if (gs !== 2'd1) begin
        n_err++;
        $display("FAIL alive tick %0d: st=%0d, want 1", k, gs);
      end
      if (k == 40) begin
        n_vec++;
        if (rex_y !== 16'd16) begin
          n_err++;
          $display("FAIL relaunch_40: rex_y=%0d, want 16", rex_y);
        end
      end
      if (k == 46) begin
        n_vec++;
        if (score !== 16'd1 || obs_left[31:16] !== 16'd0) begin
          n_err++;
          $display("FAIL tick46: score=%0d slot1=%0d, want 1 0",
                   score, obs_left[31:16]);
        end
      end
      if (k == 47) begin
        n_vec++;
        if (score !== 16'd2 || obs_valid !== 2'b11 ||
            obs_left !== {16'd240, 16'd120}) begin
          n_err++;
          $display("FAIL tick47: score=%0d v=%b obs=%h, want 2 11 00f00078",
                   score, obs_valid, obs_left);
        end
      end
      if (k == 48) begin
        n_vec++;
        if (obs_left !== {E48_1, E48_0}) begin
          n_err++;
          $display("FAIL speed_step: obs=%h, want %h", obs_left, {E48_1, E48_0});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_vec++;
    if ({rex_y, obs_left, obs_valid, score, gs} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: rex_y=%0d obs=%h v=%b score=%0d st=%0d, want all 0",
               rex_y, obs_left, obs_valid, score, gs);
    end
  endtask

  task automatic test_collision();
    key();
    for (int k = 1; k <= 28; k++) tick();
    n_vec++;
    if (obs_left[15:0] !== 16'd24 || gs !== 2'd1) begin
      n_err++;
      $display("FAIL pre_hit: slot0=%0d st=%0d, want 24 1", obs_left[15:0], gs);
    end
    @(negedge clk);
    n_vec++;
    if (gs !== 2'd3) begin
      n_err++;
      $display("FAIL hit: st=%0d, want 3", gs);
    end
    repeat (5) tick();
    n_vec++;
    if (obs_left !== {16'd144, 16'd24} || score !== 16'd0 || gs !== 2'd3) begin
      n_err++;
      $display("FAIL frozen: obs=%h score=%0d st=%0d, want 00900018 0 3",
               obs_left, score, gs);
    end
    key();
    n_vec++;
    if ({rex_y, obs_left, obs_valid, score, gs} !== '0) begin
      n_err++;
      $display("FAIL over_to_init: obs=%h v=%b score=%0d st=%0d, want all 0",
               obs_left, obs_valid, score, gs);
    end
  endtask

  initial begin
    test_reset();
    test_init_idle();
    test_spawn();
    test_jump();
    test_score();
    test_reset_mid();
    test_collision();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rex_game_core.md
# rex_game_core

Parametrised game-logic core for the Rex runner. It runs the game state machine and a velocity/gravity jump model for the dinosaur. It also manages up to N_OBS concurrently moving obstacles, detects collisions, keeps a score, and optionally raises obstacle speed as the score grows. It sits between the key debouncer / 6 Hz divider and the VGA renderer, which consumes rex_y, obs_left, obs_valid, score and game_state.

## Interface
Parameters:
- N_OBS, 2 — obstacle slots (1..4)
- REX_X, 16 — dinosaur left x
- REX_W, 16 — dinosaur width
- OBS_W, 16 — obstacle width
- OBS_H, 26 — obstacle height
- JUMP_V, 16 — initial upward velocity, px/tick
- GRAVITY, 2 — velocity decrement per tick
- SPAWN_X, 240 — spawn x of a new obstacle
- OBS_GAP, 120 — minimum distance travelled by the newest obstacle before the next spawn
- SPEED0, 8 — base obstacle speed, px/tick
- SPEED_MAX, 16 — speed ceiling
- SPEEDUP_PTS, 10 — points per speed step

Ports:
- clk120kHz  in  1  system clock
- rst  in  1  synchronous, active-high reset
- clk6Hz  in  1  6 Hz game-tick square wave, same clock domain
- in_up  in  1  jump/start key, debounced level
- rex_y  out  16  dinosaur height above ground
- obs_left  out  16*N_OBS  packed obstacle left x; slot i at [16i+15:16i]
- obs_valid  out  N_OBS  slot active
- score  out  16  obstacles passed, saturating
- game_state  out  2  0=INIT, 1=PLAYING, 3=OVER

## Operation
- tick = clk6Hz & ~clk6Hz_d (registered history). key_edge = in_up & ~in_up_d.
- **INIT**: rex_y=0, vy=0, all slots invalid, obs_left=0, score=0, speed=SPEED0. key_edge moves to PLAYING. That edge does not latch a jump.
- **PLAYING**:
  - A key_edge sets jump_req.
  - On tick, the jump step runs:
    - Grounded (rex_y=0, vy=0) with jump_req: vy=JUMP_V, rex_y unchanged this tick.
    - Airborne (vy≠0 or rex_y≠0), with signed vy: next = rex_y+vy, then vy -= GRAVITY. If next ≤ 0, set rex_y=0 and vy=0.
    - jump_req is cleared on every tick, whether consumed or discarded (airborne).
  - On tick, every valid slot moves: if obs_left < speed, the slot goes invalid and score += 1 (saturating at 16'hFFFF). Otherwise obs_left -= speed.
  - Spawn on the same tick: if no valid slot has obs_left > SPAWN_X−OBS_GAP (evaluated on post-move values) and a free slot exists, the lowest-index free slot gets obs_left=SPAWN_X and goes valid. At most one spawn per tick.
  - Collision is evaluated combinationally every clock on registered values. For any valid i: obs_left_i < REX_X+REX_W, obs_left_i+OBS_W > REX_X, and rex_y < OBS_H. A hit sets game_state=OVER at the next edge.
- **OVER**: all positions, score and vy are frozen. key_edge moves to INIT, which clears them.
- Width rules:
  - vy is 8-bit signed.
  - Height arithmetic is 17-bit signed.
  - Obstacle arithmetic is 16-bit unsigned, and the compare is done before subtracting, so no wrap.

## Timing
- All outputs are registered. Reset values: rex_y=0, obs_left=0, obs_valid=0, score=0, game_state=0. History registers are 0.
- The tick update is visible one cycle after the clk6Hz rising edge is sampled.
- Collision to OVER takes 1 cycle. If tick and hit occur in the same cycle, the hit wins: no move, jump or score change that cycle.
- key_edge and tick in the same cycle in PLAYING: the request is consumed on that tick.
- rst mid-game returns everything to reset values at the next edge.
- Jump profile with defaults (rex_y per tick after launch): 16,30,42,52,60,66,70,72,72,70,…,16,0. Airborne for 17 ticks, peak 72.

## Configuration
- REX_SPEEDUP_EN defined:
  - A point counter counts scored obstacles.
  - On reaching SPEEDUP_PTS it clears and speed += 1, capped at SPEED_MAX.
  - The new speed applies from the next tick.
- Undefined: speed is fixed at SPEED0 and the counter logic is absent.

## Test plan
- Reset with rst=1 for 3 cycles, any inputs → all outputs 0, game_state=0.
- In INIT, key_edge → game_state=1. First tick: slot0 valid at 240, rex_y=0. Next ticks: 232, 224, … Slot1 spawns on the tick slot0 reaches ≤120 (slot0=120).
- PLAYING, key_edge then 18 ticks → rex_y sequence 16,30,42,52,60,66,70,72,72,70,66,60,52,42,30,16,0. A second key_edge while airborne causes no relaunch.
- No jumps: slot0 descends to 24 (<32 and rex_y 0<26) → game_state=3 next cycle, obs_left frozen over 5 further ticks. key_edge → game_state=0 with all cleared.
- Jump timed so rex_y≥26 while slot0 overlaps → no OVER. Slot0 at 0 (<8) retires → obs_valid[0]=0, score=1.
- Force 10 scored obstacles: with REX_SPEEDUP_EN, the following move step is 9; without it, the step stays 8.
